tone_decoder: RTL and testbench

TONE_DECODER -- requirements
Module: tone_decoder

---
 rtl/tone_decoder.sv | 148 ++++++++++++++
 tb/tb_tone_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_decoder.sv
`default_nettype none
// ============================================================================
// tone_decoder : measures a square-wave tone period and locks it to a note
// Rev 1.0
// ============================================================================
module tone_decoder #(
  parameter int TIMEOUT    = 131071,
  parameter int MIN_PERIOD = 18000,
  parameter int MAX_PERIOD = 40000,
  parameter int B_CD       = 36137,
  parameter int B_DE       = 32195,
  parameter int B_EF       = 29486,
  parameter int B_FG       = 27073,
  parameter int B_GA       = 24119,
  parameter int B_AB       = 21488
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [16:0] period,
  output logic        period_valid,
  output logic [2:0]  note,
  output logic        locked,
  output logic        silent,
  output logic [7:0]  led
);

  localparam logic [16:0] C_TIMEOUT_M1 = 17'(TIMEOUT - 1);
  localparam logic [16:0] C_MIN        = 17'(MIN_PERIOD);
  localparam logic [16:0] C_MAX        = 17'(MAX_PERIOD);
  localparam logic [16:0] C_BCD        = 17'(B_CD);
  localparam logic [16:0] C_BDE        = 17'(B_DE);
  localparam logic [16:0] C_BEF        = 17'(B_EF);
  localparam logic [16:0] C_BFG        = 17'(B_FG);
  localparam logic [16:0] C_BGA        = 17'(B_GA);
  localparam logic [16:0] C_BAB        = 17'(B_AB);
  localparam logic [16:0] C_CNT_MAX    = 17'h1FFFF;
  localparam logic [2:0]  C_UNKNOWN    = 3'd7;

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    FIRST   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_edge;
  logic [16:0] r_count;
  logic [2:0]  r_cand;
  logic        r_cand_valid;

  logic [16:0] w_meas;
  logic [2:0]  w_class;
  logic        w_timeout;

  function automatic logic [2:0] classify(input logic [16:0] p);
    if (p < C_MIN || p > C_MAX) return C_UNKNOWN;
    else if (p >= C_BCD)        return 3'd0;
    else if (p >= C_BDE)        return 3'd1;
    else if (p >= C_BEF)        return 3'd2;
    else if (p >= C_BFG)        return 3'd3;
    else if (p >= C_BGA)        return 3'd4;
    else if (p >= C_BAB)        return 3'd5;
    else                        return 3'd6;
  endfunction

  function automatic logic [6:0] seg7(input logic [2:0] n);
    case (n)
      3'd0:    return 7'h39;
      3'd1:    return 7'h5E;
      3'd2:    return 7'h79;
      3'd3:    return 7'h71;
      3'd4:    return 7'h6F;
      3'd5:    return 7'h77;
      3'd6:    return 7'h7C;
      default: return 7'h40;
    endcase
  endfunction

  // The counter holds (distance - 1) at the edge cycle since it clears to 0.
  always_comb begin
    w_meas    = (r_count == C_CNT_MAX) ? C_CNT_MAX : r_count + 17'd1;
    w_class   = classify(w_meas);
    w_timeout = (r_count == C_TIMEOUT_M1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= SILENT;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_edge       <= 1'b0;
      r_count      <= 17'd0;
      r_cand       <= C_UNKNOWN;
      r_cand_valid <= 1'b0;
      period       <= 17'd0;
      period_valid <= 1'b0;
      note         <= C_UNKNOWN;
      locked       <= 1'b0;
      silent       <= 1'b1;
      led          <= 8'h00;
    end else begin
      r_sync1      <= tone_in;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_edge       <= r_sync2 & ~r_sync3;
      period_valid <= 1'b0;

      if (r_edge) begin
        r_count <= 17'd0;
        case (r_state)
          SILENT: begin
            r_state <= FIRST;
            silent  <= 1'b0;
          end
          default: begin
            r_state      <= MEASURE;
            period       <= w_meas;
            period_valid <= 1'b1;
            r_cand       <= w_class;
            r_cand_valid <= 1'b1;
            if (r_cand_valid && (w_class == r_cand)) begin
              note   <= w_class;
              locked <= 1'b1;
              led    <= {1'b1, seg7(w_class)};
            end
          end
        endcase
      end else begin
        if (r_count != C_CNT_MAX) r_count <= r_count + 17'd1;
        if (w_timeout) begin
          r_state      <= SILENT;
          silent       <= 1'b1;
          locked       <= 1'b0;
          note         <= C_UNKNOWN;
          led          <= 8'h00;
          r_cand_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_decoder.sv
`default_nettype none
// ============================================================================
// tb_tone_decoder : randomized self-checking bench with an edge-level model
// Rev 1.0
// ============================================================================
module tb_tone_decoder;

  // Timing constants scaled by 1/100 so the run stays short.
  localparam int TIMEOUT = 1310;
  localparam int MIN_P   = 180;
  localparam int MAX_P   = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tone_in;
  logic [16:0] period;
  logic        period_valid;
  logic [2:0]  note;
  logic        locked;
  logic        silent;
  logic [7:0]  led;

  always #5 clk = ~clk;

  tone_decoder #(
    .TIMEOUT   (TIMEOUT),
    .MIN_PERIOD(MIN_P),
    .MAX_PERIOD(MAX_P),
    .B_CD      (361),
    .B_DE      (322),
    .B_EF      (295),
    .B_FG      (271),
    .B_GA      (241),
    .B_AB      (215)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .period      (period),
    .period_valid(period_valid),
    .note        (note),
    .locked      (locked),
    .silent      (silent),
    .led         (led)
  );

  int         bnd [6];
  logic [6:0] seg_tab [8];
  int         bnd_list [16];

  bit has_prev;
  int cand;
  int m_note;
  bit m_locked;
  bit m_silent;
  bit exp_pending;
  int exp_period;
  int since_rise;
  int n_cmp;
  int n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int classify_ref(input int p);
    if (p < MIN_P || p > MAX_P) return 7;
    for (int k = 0; k < 6; k++)
      if (p >= bnd[k]) return k;
    return 6;
  endfunction

  function automatic logic [7:0] led_ref();
    logic [2:0] n;
    n = m_note[2:0];
    return m_locked ? {1'b1, seg_tab[n]} : 8'h00;
  endfunction

  task automatic model_timeout();
    has_prev = 1'b0;
    m_silent = 1'b1;
    m_locked = 1'b0;
    m_note   = 7;
    cand     = -1;
  endtask

  task automatic model_reset();
    model_timeout();
    exp_pending = 1'b0;
  endtask

  task automatic model_edge(input int gap);
    int c;
    int p;
    if (has_prev && gap > TIMEOUT) model_timeout();
    if (!has_prev) begin
      has_prev = 1'b1;
      m_silent = 1'b0;
    end else begin
      p = (gap > 131071) ? 131071 : gap;
      c = classify_ref(p);
      exp_period  = p;
      exp_pending = 1'b1;
      if (cand == c) begin
        m_note   = c;
        m_locked = 1'b1;
      end
      cand = c;
    end
  endtask

  task automatic sample_pv();
    if (period_valid) begin
      check_val("pv_expected", {31'd0, period_valid}, {31'd0, exp_pending});
      if (exp_pending) begin
        exp_pending = 1'b0;
        check_val("period", {15'd0, period}, exp_period);
        check_val("note", {29'd0, note}, m_note);
        check_val("locked", {31'd0, locked}, {31'd0, m_locked});
        check_val("led", {24'd0, led}, {24'd0, led_ref()});
        check_val("silent_at_pv", {31'd0, silent}, 32'd0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_period"}, {15'd0, period}, 32'd0);
    check_val({tag, "_pv"}, {31'd0, period_valid}, 32'd0);
    check_val({tag, "_note"}, {29'd0, note}, 32'd7);
    check_val({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check_val({tag, "_silent"}, {31'd0, silent}, 32'd1);
    check_val({tag, "_led"}, {24'd0, led}, 32'd0);
  endtask

  // Rising edge now, then one full period; rst_at > 0 pulses reset in that period.
  task automatic tone_period(input int p, input int rst_at);
    if (exp_pending) begin
      check_val("pv_missing", {31'd0, period_valid}, 32'd1);
      exp_pending = 1'b0;
    end
    tone_in = 1'b1;
    model_edge(since_rise);
    since_rise = 0;
    for (int i = 1; i <= p; i++) begin
      @(negedge clk);
      since_rise++;
      if (rst_at > 0 && i == rst_at + 1) begin
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        model_reset();
      end else begin
        sample_pv();
      end
      if (i == p / 2) tone_in = 1'b0;
      if (rst_at > 0 && i == rst_at) rst_n = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      since_rise++;
      sample_pv();
    end
  endtask

  task automatic check_status(input string tag);
    if (has_prev && since_rise > TIMEOUT) model_timeout();
    check_val({tag, "_silent"}, {31'd0, silent}, {31'd0, m_silent});
    check_val({tag, "_locked"}, {31'd0, locked}, {31'd0, m_locked});
    check_val({tag, "_note"}, {29'd0, note}, m_note);
    check_val({tag, "_led"}, {24'd0, led}, {24'd0, led_ref()});
  endtask

  task automatic random_group();
    int kind;
    int lo;
    int hi;
    int p;
    int reps;
    kind = $urandom_range(0, 8);
    if (kind < 7) begin
      hi = (kind == 0) ? MAX_P : bnd[kind - 1] - 1;
      lo = (kind == 6) ? MIN_P : bnd[kind];
      p  = $urandom_range(hi, lo);
    end else if (kind == 7) begin
      p = ($urandom_range(0, 1) == 0) ? $urandom_range(179, 100) : $urandom_range(480, 401);
    end else begin
      p = bnd_list[$urandom_range(0, 15)];
    end
    reps = $urandom_range(1, 3);
    for (int r = 0; r < reps; r++) tone_period(p, 0);
  endtask

  initial begin
    bnd      = '{361, 322, 295, 271, 241, 215};
    seg_tab  = '{7'h39, 7'h5E, 7'h79, 7'h71, 7'h6F, 7'h77, 7'h7C, 7'h40};
    bnd_list = '{179, 180, 214, 215, 240, 241, 270, 271,
                 294, 295, 321, 322, 360, 361, 400, 401};
    n_cmp      = 0;
    n_err      = 0;
    since_rise = 0;
    rst_n      = 1'b0;
    tone_in    = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(20);

    // Steady C: period appears on the 2nd edge, lock on the 3rd.
    repeat (3) tone_period(382, 0);
    check_val("c_lock_led", {24'd0, led}, 32'hB9);
    check_val("c_lock_note", {29'd0, note}, 32'd0);

    // C/D boundary: 361 stays C, 360 twice moves to D.
    tone_period(361, 0);
    tone_period(361, 0);
    tone_period(360, 0);
    tone_period(360, 0);
    check_val("cd_hold_note", {29'd0, note}, 32'd0);
    tone_period(360, 0);
    check_val("d_lock_led", {24'd0, led}, 32'hDE);

    // Re-lock on C, then a single G must not move the note.
    repeat (3) tone_period(382, 0);
    tone_period(255, 0);
    tone_period(255, 0);
    check_val("g_first_note", {29'd0, note}, 32'd0);
    tone_period(255, 0);
    check_val("g_lock_led", {24'd0, led}, 32'hEF);

    // Out-of-range tone locks as unknown, then silence.
    repeat (3) tone_period(100, 0);
    check_val("unk_led", {24'd0, led}, 32'hC0);
    idle(TIMEOUT - 120);
    check_status("pre_timeout");
    idle(40);
    check_status("post_timeout");
    check_val("silent_led", {24'd0, led}, 32'h00);

    // Edge exactly at the timeout count wins; one cycle later it does not.
    tone_period(300, 0);
    tone_period(300, 0);
    tone_period(1310, 0);
    tone_period(300, 0);
    tone_period(1311, 0);
    tone_period(300, 0);
    tone_period(300, 0);
    tone_period(300, 0);
    check_status("tie");

    // Reset during the low phase of a 303 period; lock needs 3 more edges.
    tone_period(303, 227);
    tone_period(303, 0);
    tone_period(303, 0);
    check_val("rst_2edge_locked", {31'd0, locked}, 32'd0);
    tone_period(303, 0);
    check_val("rst_3edge_note", {29'd0, note}, 32'd2);
    check_val("rst_3edge_locked", {31'd0, locked}, 32'd1);

    for (int k = 0; k < 16; k++) tone_period(bnd_list[k], 0);

    for (int g = 0; g < 20; g++) random_group();

    tone_period(300, 0);
    idle(50);
    if (exp_pending) check_val("pv_missing_end", {31'd0, period_valid}, 32'd1);
    check_status("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
